// File: rtl/fp_pkg.sv
// fp_pkg: shared types and constants for the FP16 ALU writeback path
// Contents: wb_kind_e (VEC/SCAL), wb_entry_t {kind, rd, data[31:0]},
//           sticky flag bit indices FFLAG_NV / FFLAG_OF, entry rd width WB_RD_W.
package fp_pkg;
    localparam int WB_RD_W = 5;
    localparam int FFLAG_NV = 1;
    localparam int FFLAG_OF = 0;
    typedef enum logic {VEC = 1'b0, SCAL = 1'b1} wb_kind_e;
    typedef struct packed {
        wb_kind_e             kind;
        logic [WB_RD_W-1:0]   rd;
        logic [31:0]          data;
    } wb_entry_t;
endpackage

// File: rtl/fp_wb_fifo.sv
// fp_wb_fifo: DEPTH-entry FIFO of writeback entries with async active-low reset
// Ports: clk, rst_n; push/din write the tail; pop retires the head;
//        head is the oldest entry (valid when count > 0); count is occupancy 0..DEPTH.
// The caller guarantees push never targets a full FIFO unless it also pops.
module fp_wb_fifo
    import fp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  wb_entry_t       din,
    input  logic            pop,
    output wb_entry_t       head,
    output logic [CW-1:0]   count
);
    wb_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
    assign head = mem[rd_ptr];
endmodule

// File: rtl/fp_wb_collector.sv
// fp_wb_collector: buffers FP16 ALU writeback results and retires them into the VRF/SRF
// Ports: in_* writeback stream from the ALU; issue_ready throttles issue;
//        vrf_* / srf_* ready/valid register-file write ports driven from the FIFO head;
//        clr_* scoreboard clear pulse on each retirement; fflags sticky {NV, OF};
//        drop_err sticky overrun indicator.
// Macro FP_WB_FFLAGS_EN: when defined, sticky FP flags are collected; otherwise fflags = 0.
module fp_wb_collector
    import fp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [RD_W-1:0] in_rd,
    input  logic [15:0]     in_data,
    input  logic            in_scalar_valid,
    input  logic [RD_W-1:0] in_scalar_rd,
    input  logic [31:0]     in_scalar_data,
    input  logic            in_err_overflow,
    input  logic            in_err_invalid,
    output logic            issue_ready,
    output logic            vrf_we,
    output logic [RD_W-1:0] vrf_waddr,
    output logic [15:0]     vrf_wdata,
    input  logic            vrf_ready,
    output logic            srf_we,
    output logic [RD_W-1:0] srf_waddr,
    output logic [31:0]     srf_wdata,
    input  logic            srf_ready,
    output logic            clr_valid,
    output logic [RD_W-1:0] clr_rd,
    output logic            clr_scalar,
    output logic [1:0]      fflags,
    input  logic            fflags_clr,
    output logic            drop_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = CW + 1;
    wb_entry_t entry, head;
    logic [CW-1:0] count;
    logic [OW-1:0] occ;
    logic push, pop, busy;
    always_comb begin
        entry.kind = in_scalar_valid ? SCAL : VEC;
        entry.rd = in_scalar_valid ? WB_RD_W'(in_scalar_rd) : WB_RD_W'(in_rd);
        entry.data = in_scalar_valid ? in_scalar_data : {16'b0, in_data};
    end
    assign busy = count != '0;
    assign vrf_we = busy && head.kind == VEC;
    assign srf_we = busy && head.kind == SCAL;
    assign vrf_waddr = RD_W'(head.rd);
    assign srf_waddr = RD_W'(head.rd);
    assign vrf_wdata = head.data[15:0];
    assign srf_wdata = head.data;
    assign pop = (vrf_we && vrf_ready) || (srf_we && srf_ready);
    assign push = in_valid && (count < CW'(DEPTH) || pop);
    assign clr_valid = pop;
    assign clr_rd = RD_W'(head.rd);
    assign clr_scalar = head.kind == SCAL;
    // One slot stays reserved for the op already sitting in the ALU output register.
    assign occ = {1'b0, count} + OW'(in_valid);
    assign issue_ready = occ < OW'(DEPTH - 1);
    fp_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (entry),
        .pop   (pop),
        .head  (head),
        .count (count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_err <= 1'b0;
        else if (in_valid && !push) drop_err <= 1'b1;
    end
`ifdef FP_WB_FFLAGS_EN
    logic [1:0] flag_in;
    always_comb begin
        flag_in = 2'b00;
        flag_in[FFLAG_NV] = in_err_invalid;
        flag_in[FFLAG_OF] = in_err_overflow;
    end
    // A clear and a flagged push in the same cycle keep the new flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fflags <= 2'b00;
        else fflags <= (fflags_clr ? 2'b00 : fflags) | (push ? flag_in : 2'b00);
    end
`else
    logic unused_flags;
    assign unused_flags = &{1'b0, fflags_clr, in_err_invalid, in_err_overflow};
    assign fflags = 2'b00;
`endif
endmodule

// File: doc/fp_wb_collector.md
# fp_wb_collector

Writeback collector for the FP16 ALU: the receiving end of its registered writeback stream. It accepts one result per cycle (vector FP16 or scalar int32 from FCVT f2i), buffers results in a small FIFO, and retires each one into the vector or scalar register file through ready/valid write ports. It also back-pressures issue, accumulates sticky FP exception flags, and pulses scoreboard clears on retirement.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `RD_W`, 5: register index width.

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  ALU writeback valid (the ALU's `wb_valid`)
- `in_rd`  in  RD_W  vector destination
- `in_data`  in  16  FP16 result
- `in_scalar_valid`  in  1  scalar result present; when set, the entry is scalar-only
- `in_scalar_rd`  in  RD_W  scalar destination
- `in_scalar_data`  in  32  int32 result
- `in_err_overflow`  in  1  overflow flag for this result
- `in_err_invalid`  in  1  NaN-input flag for this result
- `issue_ready`  out  1  issue may send an ALU op this cycle
- `vrf_we`  out  1  vector write request
- `vrf_waddr`  out  RD_W  vector write address
- `vrf_wdata`  out  16  vector write data
- `vrf_ready`  in  1  vector port accepts
- `srf_we`  out  1  scalar write request
- `srf_waddr`  out  RD_W  scalar write address
- `srf_wdata`  out  32  scalar write data
- `srf_ready`  in  1  scalar port accepts
- `clr_valid`  out  1  scoreboard clear pulse
- `clr_rd`  out  RD_W  register being cleared
- `clr_scalar`  out  1  cleared register is scalar
- `fflags`  out  2  sticky flags `{NV, OF}`
- `fflags_clr`  in  1  clear sticky flags
- `drop_err`  out  1  sticky: a result arrived while the FIFO was full

## Operation
- **Push.** An entry is pushed when `in_valid` is high and (`count < DEPTH` or a pop occurs in the same cycle).
- **Entry contents.** Each entry stores:
  - kind: VEC, or SCAL when `in_scalar_valid` is high;
  - rd: `in_scalar_rd` for SCAL, else `in_rd`;
  - data: `in_scalar_data` for SCAL, else `{16'b0, in_data}`.
- **SCAL entries.** The FP16 half of a SCAL result is discarded and never written to the VRF.
- **Head drive.** With `count > 0`, the head drives `vrf_we` (VEC) or `srf_we` (SCAL), never both.
  - Address and data come from the head and hold stable while the request is waiting.
  - Both `we` outputs are 0 when the FIFO is empty.
- **Pop.** A pop occurs on `we && ready` for the active port.
  - In the same cycle, `clr_valid` = 1, `clr_rd` = head rd, `clr_scalar` = (kind == SCAL).
- **Overrun.** `in_valid` with `count == DEPTH` and no pop: the result is dropped, `drop_err` is set, and `count` is unchanged. `drop_err` clears only on reset.
- **Issue throttle.** `issue_ready = (count + in_valid) < DEPTH - 1`, combinational. This reserves one slot for the op already in flight in the ALU's output register.
- **Pointers.** Read/write pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Simultaneous push and pop leaves `count` unchanged, including at full and at empty+1.
- **Sticky flags.** On each push, `fflags |= {in_err_invalid, in_err_overflow}`.
  - `fflags_clr` zeroes the flags.
  - If `fflags_clr` and a push carrying a flag occur in the same cycle, the set wins: the result is the new flags only.

## Timing
- **Reset values (asynchronous, applied immediately on `rst_n` low).** `count`, pointers, `fflags`, `drop_err` = 0. Therefore `vrf_we`, `srf_we`, `clr_valid` = 0 and `issue_ready` = 1 (when `in_valid` = 0).
- **Reset mid-operation** discards all buffered entries; no clear pulses are generated for them.
- **Latency.** A push on edge N makes the entry visible at the head in cycle N+1. Minimum input-to-write latency is 1 cycle; throughput is 1 result per cycle with ready held high.
- **Outputs.** `we`/addr/data are driven from registered storage; no combinational path from `in_*`.
- **Combinational paths.** `clr_*` is combinational from `ready` and the head. `issue_ready` is combinational from `in_valid` and `count`.
- **Sticky flag timing.** `fflags` updates on the edge after the push.

## Configuration
- `FP_WB_FFLAGS_EN` defined: flag bits are sampled on push and `fflags` behaves as above.
- `FP_WB_FFLAGS_EN` undefined: `fflags` is tied to `2'b00`, `fflags_clr` is ignored, and no flag logic or storage is built.
- All other behaviour is identical in both builds.

## Structure
- **Shared package `fp_pkg`:**
  - `wb_kind_e` (VEC, SCAL);
  - `wb_entry_t` struct (kind, rd, data[31:0]);
  - flag bit index constants `FFLAG_NV = 1`, `FFLAG_OF = 0`.
- **Sub-module `fp_wb_fifo`:** a parameterised `DEPTH` × `wb_entry_t` FIFO with push/pop/count and async reset. The collector wraps it with the kind decode, port steering, throttle and flag logic.

## Test plan
- **Single VEC result.** `in_valid`, rd=3, data=0x3C00, `vrf_ready`=1 → next cycle `vrf_we`=1, addr 3, data 0x3C00; `clr_valid`=1, `clr_rd`=3, `clr_scalar`=0; `srf_we`=0.
- **Scalar result.** `in_valid` and `in_scalar_valid`, scalar rd=7, data=0xFFFFFFFE → `srf_we`=1 with addr 7, data 0xFFFFFFFE; `vrf_we` never asserts; `clr_scalar`=1.
- **Backpressure.** Hold `vrf_ready`=0 and push 3 results (DEPTH=4): `issue_ready` drops once `count + in_valid` reaches 3. Release ready → three writes in push order on consecutive cycles.
- **Overrun.** Push a 5th result with FIFO full and no pop → `drop_err`=1, `count` stays 4. Push while full with a pop in the same cycle → accepted, no error.
- **Flags.** Push with `in_err_invalid`=1 → `fflags`=2'b10. Assert `fflags_clr` alongside a push with `in_err_overflow`=1 → `fflags`=2'b01. Undefined-macro build → `fflags` stays 0.
- **Reset mid-stream.** 2 entries buffered, pulse `rst_n` low between edges → `we` outputs drop immediately, `count`=0, no `clr_valid` pulses afterwards.
